id_ex_stage: RTL and testbench

- Decode-to-execute pipeline register, downstream of the register file. Consumes rs1/rs2 read data plus decoded fields and presents a registered, hazard-clean operand bundle to EX.
- Bypasses the writeback write port, because the register file returns the old value when read and written in the same cycle.
- Detects load-use hazards and inserts bubbles. Handles the EX back-pressure and pipeline-flush handshakes.

---
 rtl/id_ex_stage.sv | 183 ++++++++++++++++++
 tb/tb_id_ex_stage.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register: bypasses the writeback port into both
// source operands, inserts a bubble on load-use hazards, and honours EX stall and flush.
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [XLEN-1:0]   id_pc_i,
    input  logic [4:0]        id_rs1_addr_i,
    input  logic [4:0]        id_rs2_addr_i,
    input  logic              id_rs1_used_i,
    input  logic              id_rs2_used_i,
    input  logic [XLEN-1:0]   id_rs1_data_i,
    input  logic [XLEN-1:0]   id_rs2_data_i,
    input  logic [XLEN-1:0]   id_imm_i,
    input  logic [4:0]        id_rd_addr_i,
    input  logic              id_rd_wren_i,
    input  logic              id_mem_rd_i,
    input  logic              id_mem_wr_i,
    input  logic [CTRL_W-1:0] id_ctrl_i,
    input  logic              wb_rd_wren_i,
    input  logic [4:0]        wb_rd_addr_i,
    input  logic [XLEN-1:0]   wb_rd_data_i,
    input  logic              ex_ready_i,
    input  logic              flush_i,
    output logic              id_ready_o,
    output logic              ex_valid_o,
    output logic [XLEN-1:0]   ex_pc_o,
    output logic [4:0]        ex_rs1_addr_o,
    output logic [4:0]        ex_rs2_addr_o,
    output logic [XLEN-1:0]   ex_rs1_data_o,
    output logic [XLEN-1:0]   ex_rs2_data_o,
    output logic [XLEN-1:0]   ex_imm_o,
    output logic [4:0]        ex_rd_addr_o,
    output logic              ex_rd_wren_o,
    output logic              ex_mem_rd_o,
    output logic              ex_mem_wr_o,
    output logic [CTRL_W-1:0] ex_ctrl_o
);

    logic              valid_q, valid_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [4:0]        rs_addr_q [2];
    logic [4:0]        rs_addr_d [2];
    logic [XLEN-1:0]   rs_data_q [2];
    logic [XLEN-1:0]   rs_data_d [2];
    logic [XLEN-1:0]   imm_q, imm_d;
    logic [4:0]        rd_addr_q, rd_addr_d;
    logic              rd_wren_q, rd_wren_d;
    logic              mem_rd_q, mem_rd_d;
    logic              mem_wr_q, mem_wr_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;

    // Index 0 is rs1, index 1 is rs2.
    logic [4:0]      id_src_addr [2];
    logic [XLEN-1:0] id_src_data [2];
    logic [1:0]      id_src_used;
    logic [XLEN-1:0] src_cap_data [2];
    logic [1:0]      src_hazard;
    logic [1:0]      src_wb_hit_ex;
    logic            wb_write;
    logic            advance;
    logic            hazard;

    assign id_src_addr[0] = id_rs1_addr_i;
    assign id_src_addr[1] = id_rs2_addr_i;
    assign id_src_data[0] = id_rs1_data_i;
    assign id_src_data[1] = id_rs2_data_i;
    assign id_src_used    = {id_rs2_used_i, id_rs1_used_i};

    // x0 writes never forward: the register file ignores them too.
    assign wb_write = wb_rd_wren_i && (wb_rd_addr_i != 5'd0);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign src_cap_data[gi]  = (wb_write && (wb_rd_addr_i == id_src_addr[gi]))
                                       ? wb_rd_data_i : id_src_data[gi];
            assign src_wb_hit_ex[gi] = wb_write && (wb_rd_addr_i == rs_addr_q[gi]);
            assign src_hazard[gi]    = id_src_used[gi] && (id_src_addr[gi] == rd_addr_q);
        end
    endgenerate

    assign advance    = ex_ready_i || !valid_q;
    assign hazard     = id_valid_i && valid_q && mem_rd_q && (rd_addr_q != 5'd0) && (|src_hazard);
    assign id_ready_o = !rst_i && advance && !hazard && !flush_i;

    always_comb begin
        valid_d   = valid_q;
        pc_d      = pc_q;
        imm_d     = imm_q;
        rd_addr_d = rd_addr_q;
        rd_wren_d = rd_wren_q;
        mem_rd_d  = mem_rd_q;
        mem_wr_d  = mem_wr_q;
        ctrl_d    = ctrl_q;
        for (int i = 0; i < 2; i++) begin
            rs_addr_d[i] = rs_addr_q[i];
            rs_data_d[i] = rs_data_q[i];
        end

        if (flush_i || (advance && hazard) || (advance && !id_valid_i)) begin
            valid_d   = 1'b0;
            pc_d      = '0;
            imm_d     = '0;
            rd_addr_d = '0;
            rd_wren_d = 1'b0;
            mem_rd_d  = 1'b0;
            mem_wr_d  = 1'b0;
            ctrl_d    = '0;
            for (int i = 0; i < 2; i++) begin
                rs_addr_d[i] = '0;
                rs_data_d[i] = '0;
            end
        end else if (advance) begin
            valid_d   = 1'b1;
            pc_d      = id_pc_i;
            imm_d     = id_imm_i;
            rd_addr_d = id_rd_addr_i;
            rd_wren_d = id_rd_wren_i && (id_rd_addr_i != 5'd0);
            mem_rd_d  = id_mem_rd_i;
            mem_wr_d  = id_mem_wr_i;
            ctrl_d    = id_ctrl_i;
            for (int i = 0; i < 2; i++) begin
                rs_addr_d[i] = id_src_addr[i];
                rs_data_d[i] = src_cap_data[i];
            end
        end else if (valid_q) begin
            // Stalled in EX: pick up a producer retiring now so the operand stays current.
            for (int i = 0; i < 2; i++) begin
                if (src_wb_hit_ex[i]) begin
                    rs_data_d[i] = wb_rd_data_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q   <= 1'b0;
            pc_q      <= '0;
            imm_q     <= '0;
            rd_addr_q <= '0;
            rd_wren_q <= 1'b0;
            mem_rd_q  <= 1'b0;
            mem_wr_q  <= 1'b0;
            ctrl_q    <= '0;
            for (int i = 0; i < 2; i++) begin
                rs_addr_q[i] <= '0;
                rs_data_q[i] <= '0;
            end
        end else begin
            valid_q   <= valid_d;
            pc_q      <= pc_d;
            imm_q     <= imm_d;
            rd_addr_q <= rd_addr_d;
            rd_wren_q <= rd_wren_d;
            mem_rd_q  <= mem_rd_d;
            mem_wr_q  <= mem_wr_d;
            ctrl_q    <= ctrl_d;
            for (int i = 0; i < 2; i++) begin
                rs_addr_q[i] <= rs_addr_d[i];
                rs_data_q[i] <= rs_data_d[i];
            end
        end
    end

    assign ex_valid_o    = valid_q;
    assign ex_pc_o       = pc_q;
    assign ex_rs1_addr_o = rs_addr_q[0];
    assign ex_rs2_addr_o = rs_addr_q[1];
    assign ex_rs1_data_o = rs_data_q[0];
    assign ex_rs2_data_o = rs_data_q[1];
    assign ex_imm_o      = imm_q;
    assign ex_rd_addr_o  = rd_addr_q;
    assign ex_rd_wren_o  = rd_wren_q;
    assign ex_mem_rd_o   = mem_rd_q;
    assign ex_mem_wr_o   = mem_wr_q;
    assign ex_ctrl_o     = ctrl_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage: one task per scenario, inline checks
// against hand-computed values, one summary line at the end.
module tb_id_ex_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        id_valid_i;
    logic [31:0] id_pc_i;
    logic [4:0]  id_rs1_addr_i, id_rs2_addr_i;
    logic        id_rs1_used_i, id_rs2_used_i;
    logic [31:0] id_rs1_data_i, id_rs2_data_i, id_imm_i;
    logic [4:0]  id_rd_addr_i;
    logic        id_rd_wren_i, id_mem_rd_i, id_mem_wr_i;
    logic [7:0]  id_ctrl_i;
    logic        wb_rd_wren_i;
    logic [4:0]  wb_rd_addr_i;
    logic [31:0] wb_rd_data_i;
    logic        ex_ready_i, flush_i;
    logic        id_ready_o, ex_valid_o;
    logic [31:0] ex_pc_o;
    logic [4:0]  ex_rs1_addr_o, ex_rs2_addr_o;
    logic [31:0] ex_rs1_data_o, ex_rs2_data_o, ex_imm_o;
    logic [4:0]  ex_rd_addr_o;
    logic        ex_rd_wren_o, ex_mem_rd_o, ex_mem_wr_o;
    logic [7:0]  ex_ctrl_o;

    int tests = 0;
    int fails = 0;

    always #5 clk_i = ~clk_i;

    id_ex_stage #(.XLEN(32), .CTRL_W(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .id_valid_i(id_valid_i), .id_pc_i(id_pc_i),
        .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
        .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
        .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i),
        .id_imm_i(id_imm_i), .id_rd_addr_i(id_rd_addr_i), .id_rd_wren_i(id_rd_wren_i),
        .id_mem_rd_i(id_mem_rd_i), .id_mem_wr_i(id_mem_wr_i), .id_ctrl_i(id_ctrl_i),
        .wb_rd_wren_i(wb_rd_wren_i), .wb_rd_addr_i(wb_rd_addr_i), .wb_rd_data_i(wb_rd_data_i),
        .ex_ready_i(ex_ready_i), .flush_i(flush_i), .id_ready_o(id_ready_o),
        .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o),
        .ex_rs1_addr_o(ex_rs1_addr_o), .ex_rs2_addr_o(ex_rs2_addr_o),
        .ex_rs1_data_o(ex_rs1_data_o), .ex_rs2_data_o(ex_rs2_data_o),
        .ex_imm_o(ex_imm_o), .ex_rd_addr_o(ex_rd_addr_o), .ex_rd_wren_o(ex_rd_wren_o),
        .ex_mem_rd_o(ex_mem_rd_o), .ex_mem_wr_o(ex_mem_wr_o), .ex_ctrl_o(ex_ctrl_o)
    );

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        rst_i = 1'b0; id_valid_i = 1'b0; id_pc_i = '0;
        id_rs1_addr_i = '0; id_rs2_addr_i = '0; id_rs1_used_i = 1'b0; id_rs2_used_i = 1'b0;
        id_rs1_data_i = '0; id_rs2_data_i = '0; id_imm_i = '0; id_rd_addr_i = '0;
        id_rd_wren_i = 1'b0; id_mem_rd_i = 1'b0; id_mem_wr_i = 1'b0; id_ctrl_i = '0;
        wb_rd_wren_i = 1'b0; wb_rd_addr_i = '0; wb_rd_data_i = '0;
        ex_ready_i = 1'b1; flush_i = 1'b0;
    endtask

    task automatic set_instr(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [31:0] d1, input logic [31:0] d2,
                             input logic [4:0] rd, input logic mrd);
        id_valid_i = 1'b1; id_pc_i = pc;
        id_rs1_addr_i = rs1; id_rs2_addr_i = rs2; id_rs1_used_i = 1'b1; id_rs2_used_i = 1'b1;
        id_rs1_data_i = d1; id_rs2_data_i = d2; id_imm_i = '0;
        id_rd_addr_i = rd; id_rd_wren_i = 1'b1; id_mem_rd_i = mrd; id_mem_wr_i = 1'b0; id_ctrl_i = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_i = 1'b1; id_valid_i = 1'b1; id_pc_i = 32'hFFFF_0000;
        id_rs1_addr_i = 5'd3; id_rs2_addr_i = 5'd4; id_rs1_used_i = 1'b1; id_rs2_used_i = 1'b1;
        id_rs1_data_i = 32'h1; id_rs2_data_i = 32'h2; id_imm_i = 32'h3; id_rd_addr_i = 5'd6;
        id_rd_wren_i = 1'b1; id_mem_rd_i = 1'b1; id_mem_wr_i = 1'b1; id_ctrl_i = 8'hFF;
        #1;
        tests++; if (id_ready_o !== 1'b0) begin fails++; $display("FAIL reset_id_ready got=%0h exp=0", id_ready_o); end
        step();
        tests++; if (ex_valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid got=%0h exp=0", ex_valid_o); end
        tests++; if ({ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o} !== 128'h0) begin fails++; $display("FAIL reset_data got=%h %h %h %h exp=0", ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o); end
        tests++; if ({ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o, ex_rd_wren_o, ex_mem_rd_o, ex_mem_wr_o, ex_ctrl_o} !== 26'h0) begin fails++; $display("FAIL reset_ctrl got=%h %h %h %h %h %h %h exp=0", ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o, ex_rd_wren_o, ex_mem_rd_o, ex_mem_wr_o, ex_ctrl_o); end
        idle_inputs();
        set_instr(32'h100, 5'd1, 5'd2, 32'hA1, 32'hA2, 5'd3, 1'b0);
        #1;
        tests++; if (id_ready_o !== 1'b1) begin fails++; $display("FAIL post_reset_ready got=%0h exp=1", id_ready_o); end
        step();
        tests++; if (ex_valid_o !== 1'b1 || ex_pc_o !== 32'h100) begin fails++; $display("FAIL post_reset_capture got=%0h/%h exp=1/00000100", ex_valid_o, ex_pc_o); end
        $display("[TB] test_reset done");
    endtask

    task automatic test_bypass();
        idle_inputs();
        step();
        set_instr(32'h80, 5'd5, 5'd9, 32'h11, 32'h22, 5'd1, 1'b0);
        wb_rd_wren_i = 1'b1; wb_rd_addr_i = 5'd5; wb_rd_data_i = 32'hDEAD_BEEF;
        step();
        tests++; if (ex_rs1_data_o !== 32'hDEAD_BEEF) begin fails++; $display("FAIL bypass_rs1 got=%h exp=deadbeef", ex_rs1_data_o); end
        tests++; if (ex_rs2_data_o !== 32'h22) begin fails++; $display("FAIL bypass_rs2_nomatch got=%h exp=00000022", ex_rs2_data_o); end
        set_instr(32'h84, 5'd0, 5'd9, 32'h11, 32'h22, 5'd1, 1'b0);
        wb_rd_addr_i = 5'd0;
        step();
        tests++; if (ex_rs1_data_o !== 32'h11) begin fails++; $display("FAIL bypass_x0 got=%h exp=00000011", ex_rs1_data_o); end
        set_instr(32'h88, 5'd5, 5'd9, 32'h11, 32'h22, 5'd1, 1'b0);
        wb_rd_addr_i = 5'd9; wb_rd_data_i = 32'hCAFE;
        step();
        tests++; if (ex_rs2_data_o !== 32'hCAFE || ex_rs1_data_o !== 32'h11) begin fails++; $display("FAIL bypass_rs2 got=%h/%h exp=0000cafe/00000011", ex_rs2_data_o, ex_rs1_data_o); end
        wb_rd_wren_i = 1'b0;
        step();
        tests++; if (ex_rs2_data_o !== 32'h22) begin fails++; $display("FAIL bypass_wren_off got=%h exp=00000022", ex_rs2_data_o); end
        $display("[TB] test_bypass done");
    endtask

    task automatic test_load_use();
        idle_inputs();
        step();
        set_instr(32'h200, 5'd1, 5'd2, 32'h0, 32'h0, 5'd7, 1'b1);
        step();
        set_instr(32'h204, 5'd1, 5'd7, 32'h0, 32'h0, 5'd8, 1'b0);
        #1;
        tests++; if (id_ready_o !== 1'b0) begin fails++; $display("FAIL hazard_ready got=%0h exp=0", id_ready_o); end
        step();
        tests++; if (ex_valid_o !== 1'b0 || ex_mem_rd_o !== 1'b0 || ex_pc_o !== 32'h0) begin fails++; $display("FAIL hazard_bubble got=%0h/%0h/%h exp=0/0/0", ex_valid_o, ex_mem_rd_o, ex_pc_o); end
        tests++; if (id_ready_o !== 1'b1) begin fails++; $display("FAIL hazard_release got=%0h exp=1", id_ready_o); end
        step();
        tests++; if (ex_valid_o !== 1'b1 || ex_pc_o !== 32'h204 || ex_rs2_addr_o !== 5'd7) begin fails++; $display("FAIL hazard_capture got=%0h/%h/%0d exp=1/00000204/7", ex_valid_o, ex_pc_o, ex_rs2_addr_o); end
        set_instr(32'h210, 5'd1, 5'd2, 32'h0, 32'h0, 5'd4, 1'b1);
        step();
        set_instr(32'h214, 5'd4, 5'd4, 32'h0, 32'h0, 5'd8, 1'b0);
        #1;
        tests++; if (id_ready_o !== 1'b0) begin fails++; $display("FAIL dual_hazard_ready got=%0h exp=0", id_ready_o); end
        step();
        tests++; if (ex_valid_o !== 1'b0 || id_ready_o !== 1'b1) begin fails++; $display("FAIL dual_hazard_bubble got=%0h/%0h exp=0/1", ex_valid_o, id_ready_o); end
        step();
        tests++; if (ex_valid_o !== 1'b1 || ex_pc_o !== 32'h214) begin fails++; $display("FAIL dual_hazard_capture got=%0h/%h exp=1/00000214", ex_valid_o, ex_pc_o); end
        set_instr(32'h220, 5'd1, 5'd2, 32'h0, 32'h0, 5'd0, 1'b1);
        step();
        set_instr(32'h224, 5'd0, 5'd0, 32'h0, 32'h0, 5'd8, 1'b0);
        #1;
        tests++; if (id_ready_o !== 1'b1) begin fails++; $display("FAIL x0_hazard_ready got=%0h exp=1", id_ready_o); end
        step();
        tests++; if (ex_valid_o !== 1'b1 || ex_pc_o !== 32'h224) begin fails++; $display("FAIL x0_hazard_capture got=%0h/%h exp=1/00000224", ex_valid_o, ex_pc_o); end
        $display("[TB] test_load_use done");
    endtask

    task automatic test_stall_refresh();
        idle_inputs();
        step();
        set_instr(32'h300, 5'd3, 5'd6, 32'hAAAA, 32'hBBBB, 5'd9, 1'b0);
        step();
        ex_ready_i = 1'b0;
        set_instr(32'h400, 5'd10, 5'd11, 32'h1, 32'h2, 5'd12, 1'b0);
        #1;
        tests++; if (id_ready_o !== 1'b0) begin fails++; $display("FAIL stall_c1_ready got=%0h exp=0", id_ready_o); end
        step();
        tests++; if (ex_pc_o !== 32'h300 || ex_rs1_data_o !== 32'hAAAA) begin fails++; $display("FAIL stall_c1_hold got=%h/%h exp=00000300/0000aaaa", ex_pc_o, ex_rs1_data_o); end
        wb_rd_wren_i = 1'b1; wb_rd_addr_i = 5'd3; wb_rd_data_i = 32'h1234;
        #1;
        tests++; if (id_ready_o !== 1'b0) begin fails++; $display("FAIL stall_c2_ready got=%0h exp=0", id_ready_o); end
        step();
        tests++; if (ex_rs1_data_o !== 32'h1234 || ex_rs2_data_o !== 32'hBBBB || ex_pc_o !== 32'h300) begin fails++; $display("FAIL stall_refresh got=%h/%h/%h exp=00001234/0000bbbb/00000300", ex_rs1_data_o, ex_rs2_data_o, ex_pc_o); end
        wb_rd_wren_i = 1'b0;
        #1;
        tests++; if (id_ready_o !== 1'b0) begin fails++; $display("FAIL stall_c3_ready got=%0h exp=0", id_ready_o); end
        step();
        tests++; if (ex_rs1_data_o !== 32'h1234 || ex_pc_o !== 32'h300) begin fails++; $display("FAIL stall_c3_hold got=%h/%h exp=00001234/00000300", ex_rs1_data_o, ex_pc_o); end
        ex_ready_i = 1'b1;
        #1;
        tests++; if (id_ready_o !== 1'b1) begin fails++; $display("FAIL stall_release_ready got=%0h exp=1", id_ready_o); end
        step();
        tests++; if (ex_pc_o !== 32'h400) begin fails++; $display("FAIL stall_release_capture got=%h exp=00000400", ex_pc_o); end
        $display("[TB] test_stall_refresh done");
    endtask

    task automatic test_flush();
        idle_inputs();
        step();
        set_instr(32'h500, 5'd1, 5'd2, 32'h0, 32'h0, 5'd7, 1'b1);
        step();
        ex_ready_i = 1'b0; flush_i = 1'b1;
        set_instr(32'h504, 5'd7, 5'd2, 32'h5, 32'h6, 5'd8, 1'b0);
        #1;
        tests++; if (id_ready_o !== 1'b0) begin fails++; $display("FAIL flush_ready got=%0h exp=0", id_ready_o); end
        step();
        tests++; if (ex_valid_o !== 1'b0 || ex_pc_o !== 32'h0 || ex_mem_rd_o !== 1'b0 || ex_rd_addr_o !== 5'd0) begin fails++; $display("FAIL flush_bubble got=%0h/%h/%0h/%0d exp=0/0/0/0", ex_valid_o, ex_pc_o, ex_mem_rd_o, ex_rd_addr_o); end
        flush_i = 1'b0;
        #1;
        tests++; if (id_ready_o !== 1'b1) begin fails++; $display("FAIL flush_after_ready got=%0h exp=1", id_ready_o); end
        step();
        tests++; if (ex_valid_o !== 1'b1 || ex_pc_o !== 32'h504) begin fails++; $display("FAIL flush_after_capture got=%0h/%h exp=1/00000504", ex_valid_o, ex_pc_o); end
        $display("[TB] test_flush done");
    endtask

    task automatic test_x0_dest();
        idle_inputs();
        set_instr(32'h600, 5'd1, 5'd2, 32'h1111, 32'h2222, 5'd0, 1'b0);
        id_mem_wr_i = 1'b1; id_imm_i = 32'h77; id_ctrl_i = 8'h5A;
        step();
        tests++; if (ex_rd_wren_o !== 1'b0 || ex_rd_addr_o !== 5'd0) begin fails++; $display("FAIL x0_dest_wren got=%0h/%0d exp=0/0", ex_rd_wren_o, ex_rd_addr_o); end
        tests++; if (ex_valid_o !== 1'b1 || ex_pc_o !== 32'h600 || ex_imm_o !== 32'h77 || ex_ctrl_o !== 8'h5A || ex_mem_wr_o !== 1'b1) begin fails++; $display("FAIL x0_dest_fields got=%0h/%h/%h/%h/%0h exp=1/00000600/00000077/5a/1", ex_valid_o, ex_pc_o, ex_imm_o, ex_ctrl_o, ex_mem_wr_o); end
        tests++; if (ex_rs1_data_o !== 32'h1111 || ex_rs2_data_o !== 32'h2222) begin fails++; $display("FAIL x0_dest_data got=%h/%h exp=00001111/00002222", ex_rs1_data_o, ex_rs2_data_o); end
        id_valid_i = 1'b0;
        step();
        tests++; if (ex_valid_o !== 1'b0 || ex_pc_o !== 32'h0 || ex_imm_o !== 32'h0 || ex_ctrl_o !== 8'h0) begin fails++; $display("FAIL invalid_capture got=%0h/%h/%h/%h exp=0/0/0/0", ex_valid_o, ex_pc_o, ex_imm_o, ex_ctrl_o); end
        $display("[TB] test_x0_dest done");
    endtask

    task automatic test_reset_mid_stall();
        idle_inputs();
        set_instr(32'h700, 5'd1, 5'd2, 32'h9, 32'h8, 5'd3, 1'b0);
        step();
        ex_ready_i = 1'b0; rst_i = 1'b1;
        #1;
        tests++; if (id_ready_o !== 1'b0) begin fails++; $display("FAIL rst_stall_ready got=%0h exp=0", id_ready_o); end
        step();
        tests++; if (ex_valid_o !== 1'b0 || ex_pc_o !== 32'h0 || ex_rs1_data_o !== 32'h0) begin fails++; $display("FAIL rst_stall_bubble got=%0h/%h/%h exp=0/0/0", ex_valid_o, ex_pc_o, ex_rs1_data_o); end
        rst_i = 1'b0;
        $display("[TB] test_reset_mid_stall done");
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_load_use();
        test_stall_refresh();
        test_flush();
        test_x0_dest();
        test_reset_mid_stall();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
